// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared pipeline types and constants for the stall controller
//
// Purpose : freeze FSM state encoding and the nop word loaded into flushed
//           pipeline registers.
// Ports   : none (package).
package pipe_stall_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN     = 2'b00;
  localparam state_t ST_MD_WAIT = 2'b01;
  localparam state_t ST_HALT    = 2'b10;

  // Flushed IF/ID, ID/EX and EX/MEM registers hold this encoding (sll $0,$0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - enabled free-running wrap-around event counter
//
// Purpose : counts cycles with i_en high, wrapping modulo 2^W.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset, clears the count
//           i_en  - count enable
//           o_cnt - current count
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - freeze FSM producing pipeline enables, flushes and perf counters
//
// Purpose : arbitrates halt, mult/div occupancy, load-use stalls and taken
//           branches into per-stage enables/flushes for the 5-stage pipeline.
// Ports   : clk, rst_n     - clock and asynchronous active-low reset
//           is_stall       - load-use hazard for the instruction in ID
//           md_start       - mult/div entering EX (one-cycle pulse)
//           branch_taken   - branch/jump resolved taken in ID
//           halt_req       - break/halt decoded in ID
//           pc_en, if_id_en, id_ex_en             - register enables
//           if_id_flush, id_ex_flush, ex_mem_flush - clear-to-nop controls
//           md_busy, halted                       - status
//           stall_cnt, flush_cnt                  - performance counters
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             is_stall,
  input  logic             md_start,
  input  logic             branch_taken,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             md_busy,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MD_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [MD_W-1:0] r_md_cnt;
  logic [MD_W-1:0] w_md_cnt_nxt;
  logic            w_stall_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;

    case (r_state)
      ST_RUN: begin
        if (halt_req) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_en    = 1'b0;
          id_ex_flush = 1'b1;
          w_state_nxt = ST_HALT;
        end else begin
          // EX only freezes from the next cycle, so the issue cycle still
          // obeys the stall/branch rules below.
          if (md_start) begin
            w_state_nxt  = ST_MD_WAIT;
            w_md_cnt_nxt = MD_W'(MD_LATENCY - 1);
          end
          if (is_stall) begin
            // Branch operands in ID are stale during a load-use stall, so
            // branch_taken is deliberately ignored here.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (branch_taken && (DELAY_SLOT == 0)) begin
            if_id_flush = 1'b1;
          end
        end
      end

      ST_MD_WAIT: begin
        // halt_req is not looked at here; it is picked up on the first RUN
        // cycle if ID still holds the break.
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
        w_md_cnt_nxt = r_md_cnt - MD_W'(1);
        if (r_md_cnt == MD_W'(1)) begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_HALT: begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_ex_en = 1'b0;
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign md_busy     = (r_state == ST_MD_WAIT);
  assign halted      = (r_state == ST_HALT);
  assign w_stall_inc = !pc_en && (r_state != ST_HALT);

  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_stall_inc),
    .o_cnt (stall_cnt)
  );

  perf_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (if_id_flush),
    .o_cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       is_stall, md_start, branch_taken, halt_req;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush;
  logic       md_busy, halted;
  logic [3:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .MD_LATENCY (4),
    .DELAY_SLOT (0),
    .CNT_W      (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .is_stall     (is_stall),
    .md_start     (md_start),
    .branch_taken (branch_taken),
    .halt_req     (halt_req),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_en     (id_ex_en),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .md_busy      (md_busy),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs packed as {pc_en,if_id_en,id_ex_en,if_id_flush,id_ex_flush,ex_mem_flush,md_busy,halted}
  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    chk(tag, {24'h0, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
              ex_mem_flush, md_busy, halted}, {24'h0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; is_stall = 1'b0; md_start = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
    #3;
    chk_ctl("reset_ctl", 8'b1110_0000);
    chk("reset_stall_cnt", {28'h0, stall_cnt}, 32'd0);
    chk("reset_flush_cnt", {28'h0, flush_cnt}, 32'd0);
    #9 rst_n = 1'b1;
    cyc();

    // Load-use stall for two cycles
    is_stall = 1'b1; #1;
    chk_ctl("stall_c1", 8'b0010_1000);
    cyc(); #1;
    chk_ctl("stall_c2", 8'b0010_1000);
    cyc();
    is_stall = 1'b0; #1;
    chk_ctl("stall_done", 8'b1110_0000);
    chk("stall_cnt_2", {28'h0, stall_cnt}, 32'd2);

    // Mult/div freeze: issue cycle runs normally, then 3 frozen cycles
    md_start = 1'b1; #1;
    chk_ctl("md_issue", 8'b1110_0000);
    cyc();
    md_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk_ctl($sformatf("md_wait_%0d", i), 8'b0000_0110);
      cyc();
    end
    #1 chk_ctl("md_back_run", 8'b1110_0000);
    chk("stall_cnt_md", {28'h0, stall_cnt}, 32'd5);

    // Branch masked by stall, then flushes on its own
    is_stall = 1'b1; branch_taken = 1'b1; #1;
    chk_ctl("br_masked", 8'b0010_1000);
    cyc();
    is_stall = 1'b0; #1;
    chk_ctl("br_flush", 8'b1111_0000);
    cyc();
    branch_taken = 1'b0; #1;
    chk("flush_cnt_1", {28'h0, flush_cnt}, 32'd1);
    chk("stall_cnt_br", {28'h0, stall_cnt}, 32'd6);

    // Halt deferred through MD_WAIT, taken on first RUN cycle
    md_start = 1'b1; #1;
    chk_ctl("md2_issue", 8'b1110_0000);
    cyc();
    md_start = 1'b0; halt_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk_ctl($sformatf("md2_wait_halt_%0d", i), 8'b0000_0110);
      cyc();
    end
    #1 chk_ctl("halt_entry", 8'b0000_1000);
    cyc();
    #1 chk_ctl("halted", 8'b0000_0001);
    chk("stall_cnt_halt", {28'h0, stall_cnt}, 32'd10);
    halt_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      is_stall = i[0]; branch_taken = ~i[0]; md_start = (i == 3);
      cyc();
    end
    is_stall = 1'b0; branch_taken = 1'b0; md_start = 1'b0; #1;
    chk_ctl("halt_absorb", 8'b0000_0001);
    chk("halt_stall_frozen", {28'h0, stall_cnt}, 32'd10);
    chk("halt_flush_frozen", {28'h0, flush_cnt}, 32'd1);

    // Asynchronous reset out of HALT, between edges
    #1 rst_n = 1'b0; #1;
    chk_ctl("rst_halt_ctl", 8'b1110_0000);
    chk("rst_halt_stall", {28'h0, stall_cnt}, 32'd0);
    chk("rst_halt_flush", {28'h0, flush_cnt}, 32'd0);
    #1 rst_n = 1'b1;
    cyc();

    // Asynchronous reset mid MD_WAIT
    md_start = 1'b1;
    cyc();
    md_start = 1'b0; #1;
    chk_ctl("md3_wait", 8'b0000_0110);
    #1 rst_n = 1'b0; #1;
    chk_ctl("rst_md_ctl", 8'b1110_0000);
    chk("rst_md_stall", {28'h0, stall_cnt}, 32'd0);
    #1 rst_n = 1'b1;
    cyc();

    // 17 stall cycles on a 4-bit counter wrap to 1
    is_stall = 1'b1;
    for (int i = 0; i < 17; i++) cyc();
    is_stall = 1'b0; #1;
    chk("stall_wrap", {28'h0, stall_cnt}, 32'd1);
    chk("wrap_flush", {28'h0, flush_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
